// File: rtl/time_set_pkg.sv
// time_set_pkg
// Shared definitions for the time-set controller: the set-mode state enum,
// the clock-field limits and widths, and wrap-around increment helpers used
// when editing hours and minutes.
package time_set_pkg;

    localparam int HRS_W  = 5;
    localparam int MINS_W = 6;

    localparam logic [HRS_W-1:0]  MAX_HRS  = HRS_W'(23);
    localparam logic [MINS_W-1:0] MAX_MINS = MINS_W'(59);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HRS  = 2'd1,
        ST_SET_MINS = 2'd2
    } state_t;

    // >= rather than == so an out-of-range value loaded from the counter
    // still lands back in range on the next increment.
    function automatic logic [HRS_W-1:0] next_hrs(input logic [HRS_W-1:0] h);
        return (h >= MAX_HRS) ? '0 : h + 1'b1;
    endfunction

    function automatic logic [MINS_W-1:0] next_mins(input logic [MINS_W-1:0] m);
        return (m >= MAX_MINS) ? '0 : m + 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Two-flop synchronizer, debounce counter and rising-edge press pulse for one
// raw push button.
//   clk, reset : clock, synchronous active-high reset
//   btn        : raw asynchronous button level (active-high)
//   press      : one-cycle pulse on a debounced press (never on release)
//   held       : debounced level, only when the button is armed
//                (present only when TIME_SET_AUTO_REPEAT_EN is defined)
// A button that is already down when reset is released is not armed: it
// produces no press until it has been seen released once.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
`ifdef TIME_SET_AUTO_REPEAT_EN
    output logic held,
`endif
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [1:0]    fill_q;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_d;
    logic          armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            fill_q  <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            // fill_q[1] marks that sync_q[1] now reflects the real pin
            // rather than the reset value of the synchronizer.
            fill_q  <= {fill_q[0], 1'b1};
            level_d <= level;

            // Count consecutive cycles where the synchronized input
            // disagrees with the accepted level; any agreement restarts it.
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_q[1];
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (!armed && fill_q[1] && !sync_q[1] && !level)
                armed <= 1'b1;
        end
    end

    assign press = armed & level & ~level_d;

`ifdef TIME_SET_AUTO_REPEAT_EN
    assign held = armed & level;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl
// Two-button clock time-setting controller. Mode steps RUN -> SET_HRS ->
// SET_MINS -> RUN; inc bumps the field being edited with wrap-around. Leaving
// SET_MINS with mode loads the edited time into the timekeeping counter;
// leaving by idle timeout discards the edit.
//   clk, reset           : clock, synchronous active-high reset
//   btn_mode, btn_inc    : raw asynchronous buttons
//   cur_hrs, cur_mins    : running time from the timekeeping counter
//   run_en               : timekeeping counter enable (0 while editing)
//   load_stb             : one-cycle load strobe for load_hrs/load_mins
//   load_hrs, load_mins  : edit registers (valid while load_stb = 1)
//   disp_hrs, disp_mins  : time to display
//   blank_mask           : per-digit blank, bit0 = mins LS ... bit3 = hrs MS
// Optional feature macro TIME_SET_AUTO_REPEAT_EN: holding inc in a set state
// repeats the increment every DEBOUNCE_CYCLES*32 cycles, starting
// DEBOUNCE_CYCLES*64 cycles after the press.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_BIT       = 25,
    parameter int TIMEOUT_CYCLES  = 1_000_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic [HRS_W-1:0]  cur_hrs,
    input  logic [MINS_W-1:0] cur_mins,
    output logic              run_en,
    output logic              load_stb,
    output logic [HRS_W-1:0]  load_hrs,
    output logic [MINS_W-1:0] load_mins,
    output logic [HRS_W-1:0]  disp_hrs,
    output logic [MINS_W-1:0] disp_mins,
    output logic [3:0]        blank_mask
);

    localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    state_t              state;
    logic [HRS_W-1:0]    edit_hrs;
    logic [MINS_W-1:0]   edit_mins;
    logic [IW-1:0]       idle_cnt;
    logic [BLINK_BIT:0]  blink_cnt;
    logic                mode_press;
    logic                inc_press;
    logic                inc_evt;
    logic                blink_phase;

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int REP_FIRST = DEBOUNCE_CYCLES * 64;
    localparam int RW        = $clog2(REP_FIRST);
    localparam logic [RW-1:0] REP_LAST   = RW'(REP_FIRST - 1);
    localparam logic [RW-1:0] REP_RELOAD = RW'(DEBOUNCE_CYCLES * 32);

    logic          mode_held;
    logic          inc_held;
    logic [RW-1:0] rep_cnt;
    logic          rep_fire;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_mode),
        .held  (mode_held),
        .press (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_inc),
        .held  (inc_held),
        .press (inc_press)
    );

    assign rep_fire = inc_held && (state != ST_RUN) && (rep_cnt == REP_LAST);

    // After the first repeat the counter restarts at 32*D, so later repeats
    // come every 32*D cycles. No repeat while mode is also held down.
    always_ff @(posedge clk) begin
        if (reset || !inc_held || mode_held || (state == ST_RUN) ||
            inc_press || mode_press) begin
            rep_cnt <= '0;
        end else if (rep_fire) begin
            rep_cnt <= REP_RELOAD;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    assign inc_evt = inc_press | rep_fire;
`else
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_mode),
        .press (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_inc),
        .press (inc_press)
    );

    assign inc_evt = inc_press;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blink_phase = blink_cnt[BLINK_BIT];

    // Mode is tested before inc in each set state, so a mode press in the
    // same cycle as an inc press wins and the inc is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            run_en    <= 1'b1;
            load_stb  <= 1'b0;
            edit_hrs  <= '0;
            edit_mins <= '0;
            idle_cnt  <= '0;
        end else begin
            load_stb <= 1'b0;
            case (state)
                ST_RUN: begin
                    idle_cnt <= '0;
                    if (mode_press) begin
                        state     <= ST_SET_HRS;
                        run_en    <= 1'b0;
                        edit_hrs  <= cur_hrs;
                        edit_mins <= cur_mins;
                    end
                end
                ST_SET_HRS: begin
                    if (mode_press) begin
                        state    <= ST_SET_MINS;
                        idle_cnt <= '0;
                    end else if (inc_evt) begin
                        edit_hrs <= next_hrs(edit_hrs);
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        state    <= ST_RUN;
                        run_en   <= 1'b1;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_SET_MINS: begin
                    if (mode_press) begin
                        state    <= ST_RUN;
                        run_en   <= 1'b1;
                        load_stb <= 1'b1;
                        idle_cnt <= '0;
                    end else if (inc_evt) begin
                        edit_mins <= next_mins(edit_mins);
                        idle_cnt  <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        state    <= ST_RUN;
                        run_en   <= 1'b1;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    run_en   <= 1'b1;
                    idle_cnt <= '0;
                end
            endcase
        end
    end

    assign load_hrs  = edit_hrs;
    assign load_mins = edit_mins;

    always_comb begin
        disp_hrs   = cur_hrs;
        disp_mins  = cur_mins;
        blank_mask = 4'b0000;
        if (state != ST_RUN) begin
            disp_hrs  = edit_hrs;
            disp_mins = edit_mins;
        end
        if (blink_phase) begin
            if (state == ST_SET_HRS)
                blank_mask = 4'b1100;
            else if (state == ST_SET_MINS)
                blank_mask = 4'b0011;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl
// Bench for time_set_ctrl with short debounce/blink/timeout parameters.
// Inputs are driven just after the falling edge and outputs sampled at the
// falling edge. A press-level model (state number plus edit values with
// modulo arithmetic) predicts the visible outputs; expected loads are queued
// and matched whenever load_stb is seen.
module tb_time_set_ctrl;

    localparam int D  = 4;
    localparam int BB = 3;
    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] cur_hrs;
    logic [5:0] cur_mins;
    logic       run_en;
    logic       load_stb;
    logic [4:0] load_hrs;
    logic [5:0] load_mins;
    logic [4:0] disp_hrs;
    logic [5:0] disp_mins;
    logic [3:0] blank_mask;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .BLINK_BIT       (BB),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cur_hrs    (cur_hrs),
        .cur_mins   (cur_mins),
        .run_en     (run_en),
        .load_stb   (load_stb),
        .load_hrs   (load_hrs),
        .load_mins  (load_mins),
        .disp_hrs   (disp_hrs),
        .disp_mins  (disp_mins),
        .blank_mask (blank_mask)
    );

    // ---------------- scoreboard state ----------------
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    bit          prev_ld = 1'b0;
    logic [10:0] exp_q[$];

    // Press-level reference model: 0 = running, 1 = editing hours,
    // 2 = editing minutes.
    int m_state = 0;
    int m_eh    = 0;
    int m_em    = 0;

    typedef struct {
        bit m;
        bit i;
        int e_run;
        int e_dh;
        int e_dm;
        bit ld;
        int lh;
        int lm;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: wait for the falling edge, track cycles since reset (the
    // blink phase), and score any load strobe against the expected queue.
    task automatic tick();
        logic [10:0] e;
        @(negedge clk);
        if (reset) cyc = 0;
        else cyc++;
        if (load_stb) begin
            check("load_run_en", int'(run_en), 1);
            check("load_stb_width", int'(prev_ld), 0);
            check("load_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("load_hrs", int'(load_hrs), int'(e[10:6]));
                check("load_mins", int'(load_mins), int'(e[5:0]));
            end
        end
        prev_ld = load_stb;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input bit m, input bit i, input int hold);
        btn_mode = m;
        btn_inc  = i;
        wait_cycles(hold);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        wait_cycles(10);
    endtask

    task automatic model_op(input bit m, input bit i);
        if (m) begin
            case (m_state)
                0: begin
                    m_state = 1;
                    m_eh    = int'(cur_hrs);
                    m_em    = int'(cur_mins);
                end
                1: m_state = 2;
                default: begin
                    m_state = 0;
                    exp_q.push_back({5'(m_eh), 6'(m_em)});
                end
            endcase
        end else if (i) begin
            if (m_state == 1) m_eh = (m_eh + 1) % 24;
            else if (m_state == 2) m_em = (m_em + 1) % 60;
        end
    endtask

    task automatic do_op(input bit m, input bit i, input int hold);
        model_op(m, i);
        press(m, i, hold);
    endtask

    task automatic check_view(input string tag);
        check({tag, "_run_en"}, int'(run_en), (m_state == 0) ? 1 : 0);
        check({tag, "_disp_hrs"}, int'(disp_hrs), (m_state == 0) ? int'(cur_hrs) : m_eh);
        check({tag, "_disp_mins"}, int'(disp_mins), (m_state == 0) ? int'(cur_mins) : m_em);
    endtask

    function automatic int exp_blank(input int st);
        if (((cyc >> BB) & 1) == 0) return 0;
        if (st == 1) return 12;
        if (st == 2) return 3;
        return 0;
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Full-edit vectors with cur fixed at 22:58.
        tbl[0] = '{1'b1, 1'b0, 0, 22, 58, 1'b0, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 0, 23, 58, 1'b0, 0, 0};
        tbl[2] = '{1'b0, 1'b1, 0,  0, 58, 1'b0, 0, 0};
        tbl[3] = '{1'b1, 1'b0, 0,  0, 58, 1'b0, 0, 0};
        tbl[4] = '{1'b0, 1'b1, 0,  0, 59, 1'b0, 0, 0};
        tbl[5] = '{1'b0, 1'b1, 0,  0,  0, 1'b0, 0, 0};
        tbl[6] = '{1'b1, 1'b0, 1, 22, 58, 1'b1, 0, 0};
        tbl[7] = '{1'b0, 1'b1, 1, 22, 58, 1'b0, 0, 0};

        // ---------------- reset ----------------
        reset    = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cur_hrs  = 5'd12;
        cur_mins = 6'd34;
        wait_cycles(3);
        reset = 1'b0;
        tick();
        check("rst_run_en", int'(run_en), 1);
        check("rst_load_stb", int'(load_stb), 0);
        check("rst_disp_hrs", int'(disp_hrs), 12);
        check("rst_disp_mins", int'(disp_mins), 34);
        check("rst_blank", int'(blank_mask), 0);
        check("rst_load_hrs", int'(load_hrs), 0);
        check("rst_load_mins", int'(load_mins), 0);
        wait_cycles(5);

        // ---------------- glitch rejection ----------------
        btn_mode = 1'b1;
        wait_cycles(3);
        btn_mode = 1'b0;
        wait_cycles(12);
        check_view("glitch");

        // ---------------- table: full edit with wraps ----------------
        cur_hrs  = 5'd22;
        cur_mins = 6'd58;
        for (int k = 0; k < 8; k++) begin
            if (tbl[k].ld) exp_q.push_back({5'(tbl[k].lh), 6'(tbl[k].lm)});
            press(tbl[k].m, tbl[k].i, 6);
            check($sformatf("tbl%0d_run_en", k), int'(run_en), tbl[k].e_run);
            check($sformatf("tbl%0d_disp_hrs", k), int'(disp_hrs), tbl[k].e_dh);
            check($sformatf("tbl%0d_disp_mins", k), int'(disp_mins), tbl[k].e_dm);
        end
        m_state = 0;

        // ---------------- simultaneous mode + inc in SET_HRS ----------------
        cur_hrs  = 5'd5;
        cur_mins = 6'd30;
        do_op(1'b1, 1'b0, 6);
        cur_hrs  = 5'd7;
        cur_mins = 6'd7;
        do_op(1'b1, 1'b1, 6);
        check_view("simul");
        check("simul_edit_hrs", int'(disp_hrs), 5);

        // ---------------- blink in SET_MINS ----------------
        for (int k = 0; k < 24; k++) begin
            tick();
            check("blink_mins", int'(blank_mask), exp_blank(2));
        end
        do_op(1'b1, 1'b0, 6);
        check_view("simul_exit");
        check("run_blank", int'(blank_mask), 0);

        // ---------------- timeout from SET_MINS ----------------
        cur_hrs  = 5'd10;
        cur_mins = 6'd20;
        do_op(1'b1, 1'b0, 6);
        for (int k = 0; k < 16; k++) begin
            tick();
            check("blink_hrs", int'(blank_mask), exp_blank(1));
        end
        do_op(1'b0, 1'b1, 6);
        do_op(1'b1, 1'b0, 6);
        m_state = 2;
        wait_cycles(180);
        check_view("timeout_before");
        wait_cycles(20);
        m_state = 0;
        check_view("timeout_after");
        check("timeout_no_load", exp_q.size(), 0);

        // ---------------- reset mid-edit with inc held ----------------
        cur_hrs  = 5'd3;
        cur_mins = 6'd45;
        do_op(1'b1, 1'b0, 6);
        model_op(1'b0, 1'b1);
        btn_inc = 1'b1;
        wait_cycles(12);
        check_view("held_inc_pre");
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        m_state = 0;
        wait_cycles(20);
        check_view("rst_mid");
        model_op(1'b1, 1'b0);
        btn_mode = 1'b1;
        wait_cycles(6);
        btn_mode = 1'b0;
        wait_cycles(10);
        check_view("held_inc_after_rst");
        btn_inc = 1'b0;
        wait_cycles(12);
        check_view("held_inc_released");
        do_op(1'b0, 1'b1, 6);
        check_view("repress_inc");
        do_op(1'b1, 1'b0, 6);
        do_op(1'b1, 1'b0, 6);
        check_view("rst_mid_exit");

        // ---------------- randomized press sequences ----------------
        for (int k = 0; k < 40; k++) begin
            int op;
            bit m;
            bit i;
            cur_hrs  = 5'($urandom_range(0, 23));
            cur_mins = 6'($urandom_range(0, 59));
            op = int'($urandom_range(0, 3));
            m  = (op == 0) || (op == 3);
            i  = (op != 0);
            do_op(m, i, int'($urandom_range(5, 10)));
            check_view("rand");
        end
        for (int k = 0; k < 3 && m_state != 0; k++) begin
            do_op(1'b1, 1'b0, 6);
        end
        check_view("rand_exit");
        wait_cycles(4);
        check("loads_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
